// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants, IR field accessors and FSM state type for the pipeline stall controller.
// Used by the top, the hazard detector and the interface.
package pipeline_ctrl_pkg;

    localparam logic [4:0] LW    = 5'b01000;
    localparam logic [4:0] SW    = 5'b00111;
    localparam logic [4:0] RTYPE = 5'b00000;
    localparam logic [4:0] BNE   = 5'b00010;
    localparam logic [4:0] BLT   = 5'b00110;
    localparam logic [4:0] JR    = 5'b00100;

    localparam logic [4:0] MULT  = 5'b00110;
    localparam logic [4:0] DIV   = 5'b00111;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RD_MSB     = 26;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 17;
    localparam int RT_MSB     = 16;
    localparam int RT_LSB     = 12;
    localparam int ALUOP_MSB  = 6;
    localparam int ALUOP_LSB  = 2;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    function automatic logic [4:0] get_opcode(input logic [31:0] ir);
        return ir[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [4:0] get_rs(input logic [31:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] get_rt(input logic [31:0] ir);
        return ir[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [4:0] get_aluop(input logic [31:0] ir);
        return ir[ALUOP_MSB:ALUOP_LSB];
    endfunction

    function automatic logic is_mult(input logic [31:0] ir);
        return (get_opcode(ir) == RTYPE) && (get_aluop(ir) == MULT);
    endfunction

    function automatic logic is_div(input logic [31:0] ir);
        return (get_opcode(ir) == RTYPE) && (get_aluop(ir) == DIV);
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline-side signal bundle of the stall controller; stall_cycles exists only with STALL_PERF_EN.
// All controls are level signals sampled on the rising clock edge; there is no valid/ready pairing.
interface pipeline_stall_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic [31:0] decodeIR;
    logic [31:0] executeIR;
    logic        branch_taken;
    logic        md_ready;

    logic        pc_en;
    logic        fd_en;
    logic        dx_en;
    logic        fd_flush;
    logic        dx_nop;
    logic        xm_nop;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic        md_wb_sel;
    logic        md_busy;
    logic        md_timeout;
    state_t      state;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    modport master (
`ifdef STALL_PERF_EN
        input  stall_cycles,
`endif
        output decodeIR, executeIR, branch_taken, md_ready,
        input  pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop,
        input  md_ctrl_mult, md_ctrl_div, md_wb_sel, md_busy, md_timeout, state
    );

    modport slave (
`ifdef STALL_PERF_EN
        output stall_cycles,
`endif
        input  decodeIR, executeIR, branch_taken, md_ready,
        output pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop,
        output md_ctrl_mult, md_ctrl_div, md_wb_sel, md_busy, md_timeout, state
    );

endinterface

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Combinational load-use detector: a lw in execute whose non-zero rd feeds a decode source register.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [31:0] decodeIR,
    input  logic [31:0] executeIR,
    output logic        load_use
);

    logic [4:0] dec_op;
    logic [4:0] exe_rd;
    logic       use_rt;
    logic       use_rd;
    logic       hit_rs;
    logic       hit_rt;
    logic       hit_rd;

    always_comb begin
        dec_op = get_opcode(decodeIR);
        exe_rd = get_rd(executeIR);
        use_rt = (dec_op == RTYPE);
        // Stores and register-compare branches/jr read rd as a source operand.
        use_rd = (dec_op == SW) || (dec_op == BNE) || (dec_op == BLT) || (dec_op == JR);
        hit_rs = (get_rs(decodeIR) == exe_rd);
        hit_rt = use_rt && (get_rt(decodeIR) == exe_rd);
        hit_rd = use_rd && (get_rd(decodeIR) == exe_rd);
        load_use = (get_opcode(executeIR) == LW) && (exe_rd != 5'd0)
                   && (hit_rs || hit_rt || hit_rd);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencer: load-use interlock, taken-branch flush and multdiv start/wait/hand-off.
// Optional stall_cycles performance counter is built when STALL_PERF_EN is defined.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    pipeline_stall_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MD_TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_q;
    logic             set_timeout;

    logic load_use;
    logic exe_mult;
    logic exe_div;
    logic exe_md;

    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic fd_flush;
    logic dx_nop;
    logic xm_nop;
    logic md_ctrl_mult;
    logic md_ctrl_div;
    logic md_wb_sel;

    hazard_detect u_hazard (
        .decodeIR  (bus.decodeIR),
        .executeIR (bus.executeIR),
        .load_use  (load_use)
    );

    assign exe_mult = is_mult(bus.executeIR);
    assign exe_div  = is_div(bus.executeIR);
    assign exe_md   = exe_mult || exe_div;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        set_timeout = 1'b0;
        case (state)
            RUN: begin
                if (!bus.branch_taken && exe_md) begin
                    state_nxt = MD_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            MD_WAIT: begin
                if (bus.md_ready) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_CNT) begin
                    // Abandon the operation; the flag stays set until reset.
                    state_nxt   = RUN;
                    cnt_nxt     = '0;
                    set_timeout = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are held at their reset values while reset is low, even if a mult/div sits in execute.
    always_comb begin
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        dx_en        = 1'b1;
        fd_flush     = 1'b0;
        dx_nop       = 1'b0;
        xm_nop       = 1'b0;
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        md_wb_sel    = 1'b0;
        if (reset) begin
            case (state)
                RUN: begin
                    if (bus.branch_taken) begin
                        fd_flush = 1'b1;
                        dx_nop   = 1'b1;
                    end else if (exe_md) begin
                        md_ctrl_mult = exe_mult;
                        md_ctrl_div  = exe_div;
                        pc_en        = 1'b0;
                        fd_en        = 1'b0;
                        dx_en        = 1'b0;
                        xm_nop       = 1'b1;
                    end else if (load_use) begin
                        pc_en  = 1'b0;
                        fd_en  = 1'b0;
                        dx_nop = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (bus.md_ready) begin
                        md_wb_sel = 1'b1;
                    end else if (cnt == TIMEOUT_CNT) begin
                        xm_nop = 1'b1;
                    end else begin
                        pc_en  = 1'b0;
                        fd_en  = 1'b0;
                        dx_en  = 1'b0;
                        xm_nop = 1'b1;
                    end
                end
                default: begin
                    pc_en = 1'b1;
                end
            endcase
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.fd_en        = fd_en;
    assign bus.dx_en        = dx_en;
    assign bus.fd_flush     = fd_flush;
    assign bus.dx_nop       = dx_nop;
    assign bus.xm_nop       = xm_nop;
    assign bus.md_ctrl_mult = md_ctrl_mult;
    assign bus.md_ctrl_div  = md_ctrl_div;
    assign bus.md_wb_sel    = md_wb_sel;
    assign bus.md_busy      = (state == MD_WAIT);
    assign bus.md_timeout   = timeout_q;
    assign bus.state        = state;

`ifdef STALL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (!pc_en && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: reset, load-use, rd=0 load, branch priority, mult, div timeout, mid-op reset.
module tb_pipeline_stall_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    pipeline_stall_ctrl_if bus ();

    pipeline_stall_ctrl #(
        .MD_TIMEOUT (40),
        .CNT_W      (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output vector order: pc_en fd_en dx_en fd_flush dx_nop xm_nop mult div wb_sel busy timeout
    localparam logic [10:0] IDLE = 11'b111_000_000_00;

    function automatic logic [10:0] outs();
        return {bus.pc_en, bus.fd_en, bus.dx_en, bus.fd_flush, bus.dx_nop, bus.xm_nop,
                bus.md_ctrl_mult, bus.md_ctrl_div, bus.md_wb_sel, bus.md_busy, bus.md_timeout};
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] o;
        reset            = 1'b0;
        bus.decodeIR     = 32'd0;
        bus.executeIR    = 32'd0;
        bus.branch_taken = 1'b0;
        bus.md_ready     = 1'b0;
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", o, IDLE);
        end
        step();
        bus.executeIR = mk_r(5'd5, 5'd1, 5'd2, 5'b00110);
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL reset_gates_mult got=%b exp=%b", o, IDLE);
        end
        bus.executeIR = 32'd0;
        step();
        reset = 1'b1;
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL reset_release_idle got=%b exp=%b", o, IDLE);
        end
    endtask

    task automatic test_load_use();
        logic [10:0] o;
        logic [10:0] e;
        logic [31:0] lw3;
        lw3 = mk_i(5'b01000, 5'd3, 5'd1);
        e   = 11'b001_010_000_00;
        step();
        bus.executeIR = lw3;
        bus.decodeIR  = mk_r(5'd4, 5'd3, 5'd2, 5'd0);
        #1;
        o = outs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL lu_rs_stall got=%b exp=%b", o, e);
        end
        step();
        bus.executeIR = 32'd0;
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL lu_bubble_release got=%b exp=%b", o, IDLE);
        end
        step();
        bus.executeIR = lw3;
        bus.decodeIR  = mk_r(5'd4, 5'd2, 5'd3, 5'd0);
        #1;
        o = outs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL lu_rt_stall got=%b exp=%b", o, e);
        end
        step();
        bus.decodeIR = mk_i(5'b00111, 5'd3, 5'd1);
        #1;
        o = outs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL lu_sw_rd_stall got=%b exp=%b", o, e);
        end
        step();
        bus.decodeIR = mk_i(5'b00101, 5'd3, 5'd1);
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL lu_rd_not_source got=%b exp=%b", o, IDLE);
        end
        step();
        bus.executeIR = 32'd0;
        bus.decodeIR  = 32'd0;
`ifdef STALL_PERF_EN
        #1;
        checks++;
        if (bus.stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL perf_after_lu got=%0d exp=3", bus.stall_cycles);
        end
`endif
    endtask

    task automatic test_rd_zero();
        logic [10:0] o;
        step();
        bus.executeIR = mk_i(5'b01000, 5'd0, 5'd1);
        bus.decodeIR  = mk_r(5'd4, 5'd0, 5'd0, 5'd0);
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL rd_zero_no_stall got=%b exp=%b", o, IDLE);
        end
    endtask

    task automatic test_branch();
        logic [10:0] o;
        logic [10:0] e;
        e = 11'b111_110_000_00;
        step();
        bus.executeIR    = mk_i(5'b01000, 5'd3, 5'd1);
        bus.decodeIR     = mk_r(5'd4, 5'd3, 5'd2, 5'd0);
        bus.branch_taken = 1'b1;
        #1;
        o = outs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL branch_over_lu got=%b exp=%b", o, e);
        end
        step();
        bus.executeIR = mk_r(5'd5, 5'd1, 5'd2, 5'b00110);
        bus.decodeIR  = 32'd0;
        #1;
        o = outs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL branch_over_mult got=%b exp=%b", o, e);
        end
        step();
        bus.branch_taken = 1'b0;
        bus.executeIR    = 32'd0;
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL branch_no_md_start got=%b exp=%b", o, IDLE);
        end
    endtask

    task automatic test_mult();
        logic [10:0] o;
        logic [10:0] e;
        int          pulses;
        int          busy_cnt;
        pulses   = 0;
        busy_cnt = 0;
        step();
        bus.executeIR = mk_r(5'd5, 5'd1, 5'd2, 5'b00110);
        bus.md_ready  = 1'b1;
        #1;
        o = outs();
        e = 11'b000_001_100_00;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL mult_start got=%b exp=%b", o, e);
        end
        if (bus.md_ctrl_mult === 1'b1) pulses++;
        for (int i = 1; i <= 33; i++) begin
            step();
            bus.md_ready = (i == 33);
            #1;
            o = outs();
            e = (i == 33) ? 11'b111_000_001_10 : 11'b000_001_000_10;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mult_wait_%0d got=%b exp=%b", i, o, e);
            end
            if (bus.md_ctrl_mult === 1'b1) pulses++;
            if (bus.md_busy === 1'b1) busy_cnt++;
        end
        step();
        bus.md_ready  = 1'b0;
        bus.executeIR = 32'd0;
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL mult_back_to_run got=%b exp=%b", o, IDLE);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL mult_pulse_count got=%0d exp=1", pulses);
        end
        checks++;
        if (busy_cnt != 33) begin
            errors++;
            $display("FAIL mult_busy_count got=%0d exp=33", busy_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] o;
        logic [10:0] e;
        step();
        bus.executeIR = mk_r(5'd6, 5'd1, 5'd2, 5'b00111);
        #1;
        o = outs();
        e = 11'b000_001_010_00;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL div_start got=%b exp=%b", o, e);
        end
        for (int i = 1; i <= 40; i++) begin
            step();
            #1;
            o = outs();
            e = (i == 40) ? 11'b111_001_000_10 : 11'b000_001_000_10;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL div_wait_%0d got=%b exp=%b", i, o, e);
            end
        end
        step();
        bus.executeIR = 32'd0;
        #1;
        o = outs();
        e = 11'b111_000_000_01;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL timeout_flag_set got=%b exp=%b", o, e);
        end
        for (int i = 0; i < 3; i++) step();
        o = outs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL timeout_flag_sticky got=%b exp=%b", o, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] o;
        step();
        bus.executeIR = mk_r(5'd5, 5'd1, 5'd2, 5'b00110);
        for (int i = 1; i <= 10; i++) step();
        #1;
        checks++;
        if (bus.md_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before_reset got=%b exp=1", bus.md_busy);
        end
        reset = 1'b0;
        #1;
        o = outs();
        checks++;
        if (o !== IDLE) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%b exp=%b", o, IDLE);
        end
`ifdef STALL_PERF_EN
        checks++;
        if (bus.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_perf got=%0d exp=0", bus.stall_cycles);
        end
`endif
        bus.executeIR = 32'd0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            o = outs();
            checks++;
            if (o !== IDLE) begin
                errors++;
                $display("FAIL mid_release_%0d got=%b exp=%b", i, o, IDLE);
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch();
        test_mult();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core. Sits beside the bypass unit in the Hazard directory.
- Decides per cycle whether each stage advances, holds or takes a bubble.
- Covers three cases: load-use interlock, taken-branch flush, and the multi-cycle multdiv unit (start pulse, wait, result hand-off).
- Bypass selection remains outside this block.

Parameters:
- MD_TIMEOUT, 40, max cycles in MD_WAIT before abort.
- CNT_W, 6, width of the multdiv cycle counter; must hold MD_TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- decodeIR  in  32  IR in F/D latch.
- executeIR  in  32  IR in D/X latch.
- branch_taken  in  1  execute-stage branch/jump resolved taken.
- md_ready  in  1  multdiv data_resultRDY.
- pc_en  out  1  PC write enable.
- fd_en  out  1  F/D latch enable.
- dx_en  out  1  D/X latch enable.
- fd_flush  out  1  load nop into F/D.
- dx_nop  out  1  load nop into D/X.
- xm_nop  out  1  load nop into X/M.
- md_ctrl_mult  out  1  one-cycle multdiv start, multiply.
- md_ctrl_div  out  1  one-cycle multdiv start, divide.
- md_wb_sel  out  1  X/M.O takes the multdiv result instead of the ALU result.
- md_busy  out  1  state == MD_WAIT.
- md_timeout  out  1  sticky abort flag.

Behaviour:
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- lw = 01000; sw = 00111; R-type = 00000; mult = aluop 00110; div = aluop 00111.
- Decode sources:
  - rs always.
  - rt for R-type.
  - rd for sw, bne (00010), blt (00110), jr (00100).
- Load-use hazard: executeIR is lw, its rd != 0, and its rd equals any decode source.
- States: RUN, MD_WAIT. Reset: state RUN, counter 0, md_timeout 0.
  - Outputs during and after reset until first edge: pc_en = fd_en = dx_en = 1; all others 0.
- RUN, priority high to low:
  1. branch_taken: fd_flush = 1, dx_nop = 1. No stall. Any load-use is ignored.
  2. executeIR is mult/div:
     - Pulse md_ctrl_mult or md_ctrl_div this cycle.
     - pc_en = fd_en = dx_en = 0; xm_nop = 1.
     - Next state MD_WAIT; counter = 1.
     - md_ready is ignored this cycle.
  3. Load-use hazard: pc_en = fd_en = 0; dx_nop = 1. One-cycle bubble. The next cycle re-evaluates against the bubble, so there is no repeat stall.
  4. Otherwise all enables 1, no nops.
- MD_WAIT:
  - Without md_ready: pc_en = fd_en = dx_en = 0; xm_nop = 1; counter++. No start pulses.
  - md_ready = 1:
    - md_wb_sel = 1; all enables 1; xm_nop = 0; next RUN; counter = 0.
    - A load-use hazard in decode that cycle cannot exist, because executeIR holds mult/div.
  - counter == MD_TIMEOUT and md_ready = 0:
    - md_timeout set (sticky until reset); xm_nop = 1; all enables 1; next RUN.
    - The mult/div is dropped and no writeback occurs.
- branch_taken while in MD_WAIT is ignored; it is unreachable because execute holds mult/div.
- Reset asserted mid-MD_WAIT: immediate return to RUN, outputs to reset values, no pulse on deassertion.
- Outputs are combinational from state plus inputs. State, counter and md_timeout are registered.

Optional Feature:
- Macro STALL_PERF_EN.
  - Defined: adds output stall_cycles [31:0]. Reset 0. Increments on every clock edge where pc_en == 0. Saturates at 0xFFFFFFFF.
  - Undefined: the port and its counter do not exist. All other behaviour is identical.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - opcode constants (LW, SW, RTYPE, BNE, BLT, JR);
  - aluop constants (MULT, DIV);
  - IR field bit positions;
  - the state enum {RUN, MD_WAIT}.
- One combinational sub-module, hazard_detect(decodeIR, executeIR) -> load_use. It is reusable by a future stage-level assertion checker.

Test Plan:
- Load-use: executeIR = lw $3, decodeIR = add $4,$3,$2 -> one cycle with pc_en = 0, fd_en = 0, dx_nop = 1; next cycle all enables 1.
- rd = 0 load: executeIR = lw $0, decodeIR reads $0 -> no stall.
- Branch vs load-use: branch_taken = 1 with load-use present -> fd_flush = 1, dx_nop = 1, pc_en = 1.
- Multiply: executeIR = mult, md_ready after 33 cycles:
  - md_ctrl_mult high exactly 1 cycle;
  - md_busy high 33 cycles;
  - md_wb_sel = 1 on the ready cycle;
  - back to RUN.
- Timeout: div with md_ready never asserted -> md_timeout = 1 after MD_TIMEOUT cycles in MD_WAIT, stalls released, xm_nop = 1, flag persists.
- Reset mid-operation: reset = 0 at cycle 10 of MD_WAIT -> md_busy = 0 immediately, no start pulse after release; with STALL_PERF_EN, stall_cycles = 0.
